// File: rtl/pw_gap_pkg.sv
// Shared types and constants for the pointwise global-average-pool reader.
// Holds the FSM state enum, default map geometry and scaler widths.
package pw_gap_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_SCALE,
        S_OUT
    } state_t;

    localparam int DEF_CHANNELS = 64;
    localparam int DEF_HEIGHT   = 14;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_RECIP    = 293;

    localparam int SUM_W  = 16;
    localparam int PROD_W = 25;
    localparam int SHIFT  = 16;

endpackage

// File: rtl/gap_scaler.sv
// Combinational average: (sum * RECIP) >> 16, saturated to DATA_WIDTH.
// Ports: sum (SUM_W-bit channel sum) in, avg (DATA_WIDTH) out.
module gap_scaler
    import pw_gap_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RECIP      = DEF_RECIP
) (
    input  logic [SUM_W-1:0]      sum,
    output logic [DATA_WIDTH-1:0] avg
);

    localparam int MAXV = (1 << DATA_WIDTH) - 1;

    logic [PROD_W-1:0]       product;
    logic [PROD_W-SHIFT-1:0] scaled;

    assign product = PROD_W'(sum) * PROD_W'(RECIP);
    assign scaled  = (PROD_W-SHIFT)'(product >> SHIFT);

    always_comb begin
        avg = DATA_WIDTH'(scaled);
        if (int'(scaled) > MAXV)
            avg = '1;
    end

endmodule

// File: rtl/pointwise_gap_reader.sv
// Streams a CHANNELS x HEIGHT x WIDTH map out of BRAM and emits one
// average per channel over a valid/ready output.
// Ports: clk, rst_n, start; BRAM read port (bram_en, bram_addr,
// bram_dout); result (out_valid, out_ready, out_data, out_channel);
// status (busy, done).
module pointwise_gap_reader
    import pw_gap_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14,
    parameter int RECIP      = DEF_RECIP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [5:0]            out_channel,
    output logic                  busy,
    output logic                  done
);

    localparam int MAP = HEIGHT * WIDTH;
    localparam int CW  = $clog2(MAP + 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [5:0]            channel;
    logic [SUM_W-1:0]      sum;
    logic [DATA_WIDTH-1:0] avg;

    gap_scaler #(
        .DATA_WIDTH (DATA_WIDTH),
        .RECIP      (RECIP)
    ) u_scaler (
        .sum (sum),
        .avg (avg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            channel     <= '0;
            sum         <= '0;
            bram_en     <= 1'b0;
            bram_addr   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        bram_addr <= '0;
                        bram_en   <= 1'b1;
                        channel   <= '0;
                        sum       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    // Data lags the address by one cycle, so the
                    // first cycle of a channel has nothing to add yet.
                    if (cnt != '0)
                        sum <= sum + SUM_W'(bram_dout);
                    if (cnt == CW'(MAP - 1)) begin
                        // Hold the last address: the final channel
                        // must not step past the end of the map.
                        bram_en <= 1'b0;
                        state   <= S_DRAIN;
                    end else begin
                        bram_addr <= bram_addr + 1'b1;
                        cnt       <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    sum   <= sum + SUM_W'(bram_dout);
                    state <= S_SCALE;
                end
                S_SCALE: begin
                    out_data    <= avg;
                    out_channel <= channel;
                    out_valid   <= 1'b1;
                    state       <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (channel != 6'(CHANNELS - 1)) begin
                            channel   <= channel + 1'b1;
                            sum       <= '0;
                            cnt       <= '0;
                            bram_addr <= bram_addr + 1'b1;
                            bram_en   <= 1'b1;
                            state     <= S_READ;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pointwise_gap_reader.sv
// Directed self-checking bench for pointwise_gap_reader.
// Models a one-cycle-latency BRAM and checks averages, order, stalls, reset.
module tb_pointwise_gap_reader;

    localparam int CH  = 64;
    localparam int MAP = 224;
    localparam int TOT = CH * MAP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bram_en;
    logic [13:0] bram_addr;
    logic [7:0]  bram_dout = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [5:0]  out_channel;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:TOT-1];
    logic [7:0] got_data [0:CH-1];
    int         got_ch [0:CH-1];
    int         n_out, n_done, max_addr, first_en, first_valid;
    bit         timed_out, busy_after;

    pointwise_gap_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bram_en     (bram_en),
        .bram_addr   (bram_addr),
        .bram_dout   (bram_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_channel (out_channel),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bram_en && int'(bram_addr) < TOT)
            bram_dout <= mem[bram_addr];

    task automatic fill(input int mode);
        for (int a = 0; a < TOT; a++) begin
            if (mode == 0)      mem[a] = 8'd1;
            else if (mode == 1) mem[a] = 8'd255;
            else                mem[a] = 8'(a / MAP);
        end
    endtask

    // Runs one pass with out_ready high and records what came out.
    task automatic collect_pass(input bit poke_busy, input bit restart);
        int cyc;
        n_out = 0; n_done = 0; max_addr = 0;
        first_en = -1; first_valid = -1;
        timed_out = 1'b0; busy_after = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (bram_en && first_en < 0) first_en = cyc;
            if (bram_en && int'(bram_addr) > max_addr) max_addr = int'(bram_addr);
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                if (n_out < CH) begin
                    got_data[n_out] = out_data;
                    got_ch[n_out] = int'(out_channel);
                end
                n_out++;
            end
            if (poke_busy && (cyc == 300 || cyc == 7000)) start = 1'b1;
            if (done) begin
                n_done++;
                if (restart) begin
                    start = 1'b1;
                    @(negedge clk);
                    busy_after = busy;
                    start = 1'b0;
                end else begin
                    repeat (3) begin
                        @(negedge clk);
                        if (done) n_done++;
                    end
                end
                break;
            end
            if (cyc > 20000) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bram_en, bram_addr, out_valid, out_data, out_channel, busy, done} !== '0) begin
            $display("FAIL reset_outputs got en=%0b addr=%0d v=%0b d=%0d ch=%0d busy=%0b done=%0b want all 0",
                     bram_en, bram_addr, out_valid, out_data, out_channel, busy, done);
            failures++;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bram_en !== 1'b0) begin
            $display("FAIL idle_no_start busy=%0b en=%0b want 0 0", busy, bram_en);
            failures++;
        end
    endtask

    task automatic test_ones();
        int bad = 0;
        fill(0);
        collect_pass(1'b0, 1'b1);
        checks++;
        if (timed_out !== 1'b0 || n_out !== CH) begin
            $display("FAIL ones_count got %0d outputs timeout=%0b want 64", n_out, timed_out);
            failures++;
        end
        for (int i = 0; i < CH; i++)
            if (got_data[i] !== 8'd1 || got_ch[i] !== i) bad++;
        checks++;
        if (bad !== 0) begin
            $display("FAIL ones_data got %0d bad outputs want 0 (data 1, channels in order)", bad);
            failures++;
        end
        checks++;
        if (first_valid - first_en !== MAP + 2) begin
            $display("FAIL latency got %0d want %0d", first_valid - first_en, MAP + 2);
            failures++;
        end
        checks++;
        if (max_addr !== TOT - 1) begin
            $display("FAIL max_addr got %0d want %0d", max_addr, TOT - 1);
            failures++;
        end
        checks++;
        if (n_done !== 1) begin
            $display("FAIL ones_done got %0d pulses want 1", n_done);
            failures++;
        end
        checks++;
        if (busy_after !== 1'b1) begin
            $display("FAIL start_on_done busy got %0b want 1", busy_after);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        bit seen = 1'b0;
        bit leak = 1'b0;
        int bad = 0;
        while (cyc < 3000) begin
            if (bram_en && bram_addr == 14'd1000) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!seen) begin
            $display("FAIL reach_addr_1000 got addr=%0d want 1000", bram_addr);
            failures++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bram_en, bram_addr, out_valid, out_data, out_channel, busy, done} !== '0) begin
            $display("FAIL mid_reset en=%0b addr=%0d v=%0b d=%0d busy=%0b want all 0",
                     bram_en, bram_addr, out_valid, out_data, busy);
            failures++;
        end
        rst_n = 1'b1;
        repeat (250) begin
            @(negedge clk);
            if (out_valid || busy || bram_en) leak = 1'b1;
        end
        checks++;
        if (leak !== 1'b0) begin
            $display("FAIL abandoned_pass got activity=1 want 0");
            failures++;
        end
        collect_pass(1'b0, 1'b0);
        for (int i = 0; i < CH; i++)
            if (got_data[i] !== 8'd1 || got_ch[i] !== i) bad++;
        checks++;
        if (n_out !== CH || n_done !== 1 || bad !== 0) begin
            $display("FAIL after_reset got outs=%0d dones=%0d bad=%0d want 64 1 0", n_out, n_done, bad);
            failures++;
        end
    endtask

    task automatic test_saturate();
        int bad = 0;
        fill(1);
        collect_pass(1'b0, 1'b0);
        for (int i = 0; i < CH; i++)
            if (got_data[i] !== 8'd255) bad++;
        checks++;
        if (n_out !== CH || bad !== 0) begin
            $display("FAIL all_255 got outs=%0d bad=%0d want 64 0", n_out, bad);
            failures++;
        end
    endtask

    task automatic test_ramp_busy_start();
        int bad = 0;
        fill(2);
        collect_pass(1'b1, 1'b0);
        for (int i = 0; i < CH; i++)
            if (got_data[i] !== 8'(i) || got_ch[i] !== i) bad++;
        checks++;
        if (n_out !== CH || bad !== 0) begin
            $display("FAIL ramp got outs=%0d bad=%0d want 64 0", n_out, bad);
            failures++;
        end
        checks++;
        if (n_done !== 1) begin
            $display("FAIL busy_start done got %0d pulses want 1", n_done);
            failures++;
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        int outs = 0;
        int bad = 0;
        int dones = 0;
        bit stalled = 1'b0;
        bit stable = 1'b1;
        logic [7:0]  sd;
        logic [5:0]  sc;
        logic [13:0] sa;
        sd = '0; sc = '0; sa = '0;
        fill(2);
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc < 20000) begin
            if (out_valid && out_channel == 6'd5 && !stalled) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                sd = out_data; sc = out_channel; sa = bram_addr;
                repeat (10) begin
                    @(negedge clk);
                    cyc++;
                    if (!out_valid || out_data !== sd || out_channel !== sc ||
                        bram_en !== 1'b0 || bram_addr !== sa)
                        stable = 1'b0;
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (out_data !== 8'(out_channel) || int'(out_channel) !== outs) bad++;
                outs++;
            end
            if (done) begin
                dones++;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!stalled || stable !== 1'b1) begin
            $display("FAIL stall_hold got stalled=%0b stable=%0b want 1 1", stalled, stable);
            failures++;
        end
        checks++;
        if (sd !== 8'd5 || sc !== 6'd5) begin
            $display("FAIL stall_value got d=%0d ch=%0d want 5 5", sd, sc);
            failures++;
        end
        checks++;
        if (outs !== CH || bad !== 0 || dones !== 1) begin
            $display("FAIL stall_pass got outs=%0d bad=%0d dones=%0d want 64 0 1", outs, bad, dones);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_reset_mid();
        test_saturate();
        test_ramp_busy_start();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pointwise_gap_reader.md
POINTWISE_GAP_READER -- requirements
Module: pointwise_gap_reader

Interface
REQ-001 SHALL have parameter CHANNELS, default 64, number of feature-map channels.
REQ-002 SHALL have parameter HEIGHT, default 14, map rows.
REQ-003 SHALL have parameter WIDTH, default 16, map columns.
REQ-004 SHALL have parameter DATA_WIDTH, default 8, unsigned element width.
REQ-005 SHALL have parameter ADDR_WIDTH, default 14, BRAM address width.
REQ-006 SHALL have parameter RECIP, default 293, round(65536/(HEIGHT*WIDTH)).
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, begin one full-map pass.
REQ-010 SHALL have port bram_en, output, 1, read enable to the pointwise output BRAM.
REQ-011 SHALL have port bram_addr, output, ADDR_WIDTH, read address; layout c*HEIGHT*WIDTH + r*WIDTH + col.
REQ-012 SHALL have port bram_dout, input, DATA_WIDTH, read data, one-cycle latency.
REQ-013 SHALL have port out_valid, output, 1, per-channel average available.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts the average.
REQ-015 SHALL have port out_data, output, DATA_WIDTH, channel average.
REQ-016 SHALL have port out_channel, output, 6, channel index of out_data.
REQ-017 SHALL have port busy, output, 1, high from start acceptance until done.
REQ-018 SHALL have port done, output, 1, single-cycle pulse after the last channel handshake.

Function
REQ-019 SHALL implement states IDLE, READ, DRAIN, SCALE, OUT.
REQ-020 IDLE: start=1 SHALL set bram_addr=0, bram_en=1, channel=0, sum=0, busy=1, and enter READ; start=0 SHALL remain in IDLE.
REQ-021 READ: SHALL advance bram_addr by 1 each cycle for HEIGHT*WIDTH addresses per channel, then enter DRAIN with bram_en=0.
REQ-022 bram_dout in cycle t SHALL belong to the address registered in cycle t-1 and SHALL be added to sum in cycle t; no element is dropped or counted twice.
REQ-023 DRAIN: SHALL add the final element, then enter SCALE.
REQ-024 sum SHALL be 16 bits unsigned (max 224*255=57120, no overflow).
REQ-025 SCALE: out_data SHALL equal (sum*RECIP)>>16, with a 25-bit product, saturated to 2^DATA_WIDTH-1; SHALL set out_valid=1 and enter OUT.
REQ-026 OUT: out_data, out_channel and out_valid SHALL hold stable while out_ready=0.
REQ-027 OUT, out_valid&out_ready: if channel<CHANNELS-1, SHALL clear out_valid, clear sum, increment channel, restart READ at address (channel+1)*HEIGHT*WIDTH with bram_en=1; otherwise SHALL clear out_valid and busy, pulse done, and enter IDLE.
REQ-028 Per-channel latency SHALL be HEIGHT*WIDTH+2 cycles from first address to out_valid (226 at default).
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 start coincident with done (the cycle after the final handshake) SHALL begin a new pass.
REQ-031 bram_addr SHALL never exceed CHANNELS*HEIGHT*WIDTH-1 (14335).

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, bram_en=0, bram_addr=0, out_valid=0, out_data=0, out_channel=0, busy=0, done=0, sum=0.
REQ-033 Reset mid-pass SHALL abandon the pass; no out_valid until a new start.

Structure
REQ-034 Package pw_gap_pkg SHALL hold the state enum and the default RECIP and map-size constants.
REQ-035 Sub-module gap_scaler (combinational multiply, shift, saturate) SHALL be the only child.

Verification
REQ-036 All elements 1, out_ready=1 -> 64 outputs, out_data=1, out_channel 0..63 in order, one done pulse.
REQ-037 All elements 255 -> every out_data=255 (saturation path exercised).
REQ-038 Channel c filled with value c -> out_data=c on out_channel=c for c=0..63.
REQ-039 out_ready low for 10 cycles at channel 5 -> out_data/out_channel stable, bram_en=0, no address advance.
REQ-040 rst_n low at address 1000 -> all outputs zero next cycle; after a new start, results match REQ-036.
REQ-041 start pulsed while busy -> ignored, single done pulse per pass.
